// File: rtl/sd_port_arbiter_if.sv
// Signal bundle shared by the SD sector port arbiter, its two clients and the IO controller.
// The master view belongs to the arbiter; the slave view belongs to everything around it.
interface sd_port_arbiter_if;
    logic        req0_rd;
    logic        req0_wr;
    logic [31:0] req0_lba;
    logic [7:0]  req0_din;
    logic        req0_ack;
    logic        req0_dout_strobe;
    logic        req0_din_strobe;
    logic        gnt0;
    logic        done0;
    logic        err0;

    logic        req1_rd;
    logic        req1_wr;
    logic [31:0] req1_lba;
    logic [7:0]  req1_din;
    logic        req1_ack;
    logic        req1_dout_strobe;
    logic        req1_din_strobe;
    logic        gnt1;
    logic        done1;
    logic        err1;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic [7:0]  sd_din;
    logic        sd_ack;
    logic        sd_dout_strobe;
    logic        sd_din_strobe;
    logic        sd_mounted;

    modport master (
        input  req0_rd, req0_wr, req0_lba, req0_din,
        input  req1_rd, req1_wr, req1_lba, req1_din,
        input  sd_ack, sd_dout_strobe, sd_din_strobe, sd_mounted,
        output req0_ack, req0_dout_strobe, req0_din_strobe, gnt0, done0, err0,
        output req1_ack, req1_dout_strobe, req1_din_strobe, gnt1, done1, err1,
        output sd_lba, sd_rd, sd_wr, sd_din
    );

    modport slave (
        output req0_rd, req0_wr, req0_lba, req0_din,
        output req1_rd, req1_wr, req1_lba, req1_din,
        output sd_ack, sd_dout_strobe, sd_din_strobe, sd_mounted,
        input  req0_ack, req0_dout_strobe, req0_din_strobe, gnt0, done0, err0,
        input  req1_ack, req1_dout_strobe, req1_din_strobe, gnt1, done1, err1,
        input  sd_lba, sd_rd, sd_wr, sd_din
    );
endinterface

// File: rtl/sd_port_arbiter.sv
// Round-robin arbiter and sequencer for the single SD sector port. Grants whole sectors
// to one of two clients, latches LBA and direction per grant, steers byte strobes and
// write data to the owner only, and aborts unmounted or stalled requests with an error.
module sd_port_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd10000000
) (
    input  logic              clk_ram,
    input  logic              reset,
    sd_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t      state, state_next;
    logic        ack_meta, ack_s, ack_prev;
    logic [1:0]  gnt, gnt_next;
    logic [1:0]  done, done_next;
    logic [1:0]  err, err_next;
    logic        cmd_rd, cmd_rd_next;
    logic        cmd_wr, cmd_wr_next;
    logic [31:0] lba, lba_next;
    logic        last_grant, last_grant_next;
    logic [23:0] counter, counter_next;

    logic        pend0, pend1, sel, sel_rd;
    logic        ack_rise, ack_fall;
    logic [31:0] sel_lba;

    assign pend0    = bus.req0_rd | bus.req0_wr;
    assign pend1    = bus.req1_rd | bus.req1_wr;
    assign sel      = (pend0 & pend1) ? ~last_grant : pend1;
    assign sel_rd   = sel ? bus.req1_rd : bus.req0_rd;
    assign sel_lba  = sel ? bus.req1_lba : bus.req0_lba;
    assign ack_rise = ack_s & ~ack_prev;
    assign ack_fall = ~ack_s & ack_prev;

    // Synchronize sd_ack; resetting to 1 makes IDLE wait out a transfer left running across reset.
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            ack_meta <= 1'b1;
            ack_s    <= 1'b1;
            ack_prev <= 1'b1;
        end else begin
            ack_meta <= bus.sd_ack;
            ack_s    <= ack_meta;
            ack_prev <= ack_s;
        end
    end

    // Sequencer state and every registered output.
    always_ff @(posedge clk_ram or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 2'b00;
            done       <= 2'b00;
            err        <= 2'b00;
            cmd_rd     <= 1'b0;
            cmd_wr     <= 1'b0;
            lba        <= 32'd0;
            last_grant <= 1'b1;
            counter    <= 24'd0;
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            done       <= done_next;
            err        <= err_next;
            cmd_rd     <= cmd_rd_next;
            cmd_wr     <= cmd_wr_next;
            lba        <= lba_next;
            last_grant <= last_grant_next;
            counter    <= counter_next;
        end
    end

    // Next state: arbitrate in IDLE (skipping the cycle an error pulse is out so the client can drop its request), issue, transfer, finish.
    always_comb begin
        state_next      = state;
        gnt_next        = gnt;
        done_next       = 2'b00;
        err_next        = 2'b00;
        cmd_rd_next     = cmd_rd;
        cmd_wr_next     = cmd_wr;
        lba_next        = lba;
        last_grant_next = last_grant;
        counter_next    = counter;

        case (state)
            IDLE: begin
                if (!ack_s && (err == 2'b00) && (pend0 | pend1)) begin
                    if (!bus.sd_mounted) begin
                        err_next[sel]   = 1'b1;
                        last_grant_next = sel;
                    end else begin
                        gnt_next[sel] = 1'b1;
                        lba_next      = sel_lba;
                        cmd_rd_next   = sel_rd;
                        cmd_wr_next   = ~sel_rd;
                        counter_next  = 24'd0;
                        state_next    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (counter != 24'hFFFFFF) begin
                    counter_next = counter + 24'd1;
                end
                if (ack_rise) begin
                    cmd_rd_next = 1'b0;
                    cmd_wr_next = 1'b0;
                    state_next  = XFER;
                end else if (counter == TIMEOUT - 24'd1) begin
                    cmd_rd_next     = 1'b0;
                    cmd_wr_next     = 1'b0;
                    gnt_next        = 2'b00;
                    err_next        = gnt;
                    last_grant_next = gnt[1];
                    state_next      = IDLE;
                end
            end
            XFER: begin
                if (ack_fall) begin
                    done_next  = gnt;
                    state_next = DONE;
                end
            end
            DONE: begin
                gnt_next        = 2'b00;
                last_grant_next = gnt[1];
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.gnt0   = gnt[0];
    assign bus.gnt1   = gnt[1];
    assign bus.done0  = done[0];
    assign bus.done1  = done[1];
    assign bus.err0   = err[0];
    assign bus.err1   = err[1];
    assign bus.sd_rd  = cmd_rd;
    assign bus.sd_wr  = cmd_wr;
    assign bus.sd_lba = lba;
    assign bus.sd_din = gnt[1] ? bus.req1_din : bus.req0_din;

    assign bus.req0_ack         = bus.sd_ack & gnt[0];
    assign bus.req1_ack         = bus.sd_ack & gnt[1];
    assign bus.req0_dout_strobe = bus.sd_dout_strobe & bus.sd_ack & gnt[0];
    assign bus.req1_dout_strobe = bus.sd_dout_strobe & bus.sd_ack & gnt[1];
    assign bus.req0_din_strobe  = bus.sd_din_strobe & bus.sd_ack & gnt[0];
    assign bus.req1_din_strobe  = bus.sd_din_strobe & bus.sd_ack & gnt[1];

endmodule

// File: tb/tb_sd_port_arbiter.sv
// Bench for sd_port_arbiter: scenarios push expected grants, command drops, done and
// error events into queues; a negedge monitor pops and compares as the DUT emits them.
module tb_sd_port_arbiter;
    localparam logic [23:0] TIMEOUT = 24'd16;

    logic clk_ram = 1'b0;
    logic reset;
    always #5 clk_ram = ~clk_ram;

    sd_port_arbiter_if bus();

    sd_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk_ram (clk_ram),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        int          client;
        logic [31:0] lba;
        bit          rd;
        bit          wr;
        logic [7:0]  din;
        int          n_dout;
        int          n_din;
        longint      cyc;
    } exp_t;

    exp_t   gnt_q[$];
    exp_t   drop_q[$];
    exp_t   done_q[$];
    exp_t   err_q[$];
    int     check_count = 0;
    int     pass_count  = 0;
    longint cyc = 0;

    always @(posedge clk_ram) cyc++;

    function automatic exp_t mkExp(input int client, input logic [31:0] lba, input bit rd,
                                   input bit wr, input logic [7:0] din, input int n_dout,
                                   input int n_din, input longint at);
        exp_t e;
        e.client = client;
        e.lba    = lba;
        e.rd     = rd;
        e.wr     = wr;
        e.din    = din;
        e.n_dout = n_dout;
        e.n_din  = n_din;
        e.cyc    = at;
        return e;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)",
                      name, actual, actual, expected, expected);
    endtask

    task automatic flagFailure(input string name);
        check_count++;
        $display("[TB] FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
    endtask

    // Drive one client's request lines.
    task automatic applyStimulus(input int n, input bit rd, input bit wr,
                                 input logic [31:0] lba, input logic [7:0] din);
        if (n == 0) begin
            bus.req0_rd = rd; bus.req0_wr = wr; bus.req0_lba = lba; bus.req0_din = din;
        end else begin
            bus.req1_rd = rd; bus.req1_wr = wr; bus.req1_lba = lba; bus.req1_din = din;
        end
    endtask

    // Client behaviour: hold the request until its done/err, drop it on the edge ending the pulse.
    task automatic clientTxn(input int n, input bit rd, input bit wr,
                             input logic [31:0] lba, input logic [7:0] din);
        int waited = 0;
        applyStimulus(n, rd, wr, lba, din);
        while (waited < 3000) begin
            @(negedge clk_ram);
            if (n == 0 ? (bus.done0 || bus.err0) : (bus.done1 || bus.err1)) break;
            waited++;
        end
        if (waited >= 3000) flagFailure($sformatf("client%0d_wait", n));
        @(posedge clk_ram); #1;
        applyStimulus(n, 1'b0, 1'b0, lba, din);
    endtask

    // IO controller model: on a command, raise sd_ack after ack_delay edges, strobe nbytes, drop ack.
    task automatic serveTransfer(input int client, input bit is_write, input int ack_delay, input int nbytes);
        int     waited = 0;
        longint c;
        @(negedge clk_ram);
        while (!(bus.sd_rd || bus.sd_wr) && waited < 200) begin
            @(negedge clk_ram);
            waited++;
        end
        if (waited >= 200) begin
            flagFailure("io_cmd_wait");
            return;
        end
        repeat (ack_delay) @(posedge clk_ram);
        #1;
        c = cyc;
        bus.sd_ack = 1'b1;
        drop_q.push_back(mkExp(client, 32'd0, !is_write, is_write, 8'h00, 0, 0, c + 3));
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk_ram); #1;
            if (is_write) bus.sd_din_strobe = 1'b1; else bus.sd_dout_strobe = 1'b1;
            @(posedge clk_ram); #1;
            bus.sd_din_strobe  = 1'b0;
            bus.sd_dout_strobe = 1'b0;
        end
        @(posedge clk_ram); #1;
        c = cyc;
        bus.sd_ack = 1'b0;
        done_q.push_back(mkExp(client, 32'd0, 1'b0, 1'b0, 8'h00,
                               is_write ? 0 : nbytes, is_write ? nbytes : 0, c + 3));
    endtask

    // Monitor: compare every grant, command drop, done and err the DUT presents.
    logic       prev_gnt0 = 1'b0, prev_gnt1 = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
    int         n_dout0 = 0, n_dout1 = 0, n_din0 = 0, n_din1 = 0, n_din_good = 0;
    logic [7:0] cur_din = 8'h00;

    always @(negedge clk_ram) begin
        exp_t e;
        if ((bus.gnt0 && !prev_gnt0) || (bus.gnt1 && !prev_gnt1)) begin
            if (gnt_q.size() == 0) flagFailure("unexpected_grant");
            else begin
                e = gnt_q.pop_front();
                checkOutput("gnt_client", bus.gnt1 ? 1 : 0, e.client);
                checkOutput("gnt_exclusive", bus.gnt0 & bus.gnt1, 0);
                checkOutput("gnt_lba", bus.sd_lba, e.lba);
                checkOutput("gnt_sd_rd", bus.sd_rd, e.rd);
                checkOutput("gnt_sd_wr", bus.sd_wr, e.wr);
                if (e.cyc >= 0) checkOutput("gnt_cycle", cyc, e.cyc);
                cur_din = e.din;
            end
            n_dout0 = 0; n_dout1 = 0; n_din0 = 0; n_din1 = 0; n_din_good = 0;
        end
        if (bus.req0_dout_strobe) n_dout0++;
        if (bus.req1_dout_strobe) n_dout1++;
        if (bus.req0_din_strobe)  n_din0++;
        if (bus.req1_din_strobe)  n_din1++;
        if ((bus.req0_din_strobe || bus.req1_din_strobe) && bus.sd_din == cur_din) n_din_good++;
        if ((prev_rd || prev_wr) && !(bus.sd_rd || bus.sd_wr)) begin
            if (drop_q.size() == 0) flagFailure("unexpected_cmd_drop");
            else begin
                e = drop_q.pop_front();
                checkOutput("drop_was_rd", prev_rd, e.rd);
                checkOutput("drop_was_wr", prev_wr, e.wr);
                if (e.cyc >= 0) checkOutput("drop_cycle", cyc, e.cyc);
            end
        end
        if (bus.err0 || bus.err1) begin
            if (err_q.size() == 0) flagFailure("unexpected_err");
            else begin
                e = err_q.pop_front();
                checkOutput("err_client", bus.err1 ? 1 : 0, e.client);
                checkOutput("err_single", bus.err0 & bus.err1, 0);
                checkOutput("err_gnt_clear", bus.gnt0 | bus.gnt1, 0);
                checkOutput("err_cmd_low", bus.sd_rd | bus.sd_wr, 0);
                checkOutput("err_cycle", cyc, e.cyc);
            end
        end
        if (bus.done0 || bus.done1) begin
            if (done_q.size() == 0) flagFailure("unexpected_done");
            else begin
                e = done_q.pop_front();
                checkOutput("done_client", bus.done1 ? 1 : 0, e.client);
                checkOutput("done_gnt_held", e.client == 1 ? bus.gnt1 : bus.gnt0, 1);
                checkOutput("done_cycle", cyc, e.cyc);
                checkOutput("owner_dout_strobes", e.client == 1 ? n_dout1 : n_dout0, e.n_dout);
                checkOutput("owner_din_strobes", e.client == 1 ? n_din1 : n_din0, e.n_din);
                checkOutput("other_strobes", e.client == 1 ? n_dout0 + n_din0 : n_dout1 + n_din1, 0);
                checkOutput("sd_din_bytes", n_din_good, e.n_din);
            end
        end
        prev_gnt0 = bus.gnt0;
        prev_gnt1 = bus.gnt1;
        prev_rd   = bus.sd_rd;
        prev_wr   = bus.sd_wr;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint c;
        bit     rd_seen;
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 8'h00);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 8'h00);
        bus.sd_ack = 1'b0; bus.sd_dout_strobe = 1'b0; bus.sd_din_strobe = 1'b0; bus.sd_mounted = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk_ram); #1;
        checkOutput("reset_sd_rd", bus.sd_rd, 0);
        checkOutput("reset_sd_wr", bus.sd_wr, 0);
        checkOutput("reset_sd_lba", bus.sd_lba, 0);
        checkOutput("reset_gnt0", bus.gnt0, 0);
        checkOutput("reset_gnt1", bus.gnt1, 0);
        checkOutput("reset_done", {bus.done1, bus.done0}, 0);
        checkOutput("reset_err", {bus.err1, bus.err0}, 0);
        reset = 1'b0;
        repeat (5) @(posedge clk_ram); #1;

        // Simultaneous reads: client 0 wins first, then alternation 0,1,0,1.
        $display("[TB] round-robin");
        gnt_q.push_back(mkExp(0, 32'h100, 1'b1, 1'b0, 8'h00, 0, 0, cyc + 1));
        gnt_q.push_back(mkExp(1, 32'h200, 1'b1, 1'b0, 8'h00, 0, 0, -1));
        fork
            clientTxn(0, 1'b1, 1'b0, 32'h100, 8'h00);
            clientTxn(1, 1'b1, 1'b0, 32'h200, 8'h00);
            begin serveTransfer(0, 1'b0, 2, 4); serveTransfer(1, 1'b0, 2, 4); end
        join
        @(posedge clk_ram); #1;
        gnt_q.push_back(mkExp(0, 32'h101, 1'b1, 1'b0, 8'h00, 0, 0, cyc + 1));
        gnt_q.push_back(mkExp(1, 32'h201, 1'b1, 1'b0, 8'h00, 0, 0, -1));
        fork
            clientTxn(0, 1'b1, 1'b1, 32'h101, 8'h00);
            clientTxn(1, 1'b1, 1'b0, 32'h201, 8'h00);
            begin serveTransfer(0, 1'b0, 2, 3); serveTransfer(1, 1'b0, 2, 3); end
        join

        // Full 512-byte sector read by client 0.
        $display("[TB] sector read");
        @(posedge clk_ram); #1;
        gnt_q.push_back(mkExp(0, 32'h12345, 1'b1, 1'b0, 8'h00, 0, 0, cyc + 1));
        fork
            clientTxn(0, 1'b1, 1'b0, 32'h12345, 8'h00);
            serveTransfer(0, 1'b0, 2, 512);
        join

        // Ack seen on the very cycle the counter reaches TIMEOUT-1 is a success.
        $display("[TB] ack on last count");
        @(posedge clk_ram); #1;
        gnt_q.push_back(mkExp(0, 32'h777, 1'b1, 1'b0, 8'h00, 0, 0, cyc + 1));
        fork
            clientTxn(0, 1'b1, 1'b0, 32'h777, 8'h00);
            serveTransfer(0, 1'b0, int'(TIMEOUT) - 3, 2);
        join

        // Client 1 write with data steering.
        $display("[TB] client 1 write");
        @(posedge clk_ram); #1;
        gnt_q.push_back(mkExp(1, 32'h55AA, 1'b0, 1'b1, 8'hA5, 0, 0, cyc + 1));
        fork
            clientTxn(1, 1'b0, 1'b1, 32'h55AA, 8'hA5);
            serveTransfer(1, 1'b1, 2, 8);
        join

        // No ack: client 0 times out 17 edges after raising its request, then client 1 is served.
        $display("[TB] timeout");
        @(posedge clk_ram); #1;
        c = cyc;
        gnt_q.push_back(mkExp(0, 32'h0BAD, 1'b1, 1'b0, 8'h00, 0, 0, c + 1));
        drop_q.push_back(mkExp(0, 32'd0, 1'b1, 1'b0, 8'h00, 0, 0, c + 17));
        err_q.push_back(mkExp(0, 32'd0, 1'b0, 1'b0, 8'h00, 0, 0, c + 17));
        gnt_q.push_back(mkExp(1, 32'h600D, 1'b1, 1'b0, 8'h00, 0, 0, c + 19));
        fork
            clientTxn(0, 1'b1, 1'b0, 32'h0BAD, 8'h00);
            begin repeat (3) @(posedge clk_ram); #1; clientTxn(1, 1'b1, 1'b0, 32'h600D, 8'h00); end
            begin repeat (20) @(posedge clk_ram); serveTransfer(1, 1'b0, 2, 2); end
        join

        // Card not mounted: immediate error, no command.
        $display("[TB] not mounted");
        bus.sd_mounted = 1'b0;
        @(posedge clk_ram); #1;
        err_q.push_back(mkExp(0, 32'd0, 1'b0, 1'b0, 8'h00, 0, 0, cyc + 1));
        rd_seen = 1'b0;
        fork
            clientTxn(0, 1'b1, 1'b0, 32'h99, 8'h00);
            for (int i = 0; i < 5; i++) begin @(negedge clk_ram); if (bus.sd_rd) rd_seen = 1'b1; end
        join
        checkOutput("unmounted_sd_rd", rd_seen, 0);
        bus.sd_mounted = 1'b1;

        // Reset in the middle of a transfer with sd_ack still high.
        $display("[TB] reset mid-transfer");
        @(posedge clk_ram); #1;
        c = cyc;
        gnt_q.push_back(mkExp(0, 32'h4242, 1'b1, 1'b0, 8'h00, 0, 0, c + 1));
        applyStimulus(0, 1'b1, 1'b0, 32'h4242, 8'h00);
        repeat (3) @(posedge clk_ram); #1;
        bus.sd_ack = 1'b1;
        drop_q.push_back(mkExp(0, 32'd0, 1'b1, 1'b0, 8'h00, 0, 0, cyc + 3));
        repeat (5) @(posedge clk_ram); #1;
        reset = 1'b1;
        #1;
        checkOutput("midreset_sd_rd", bus.sd_rd, 0);
        checkOutput("midreset_gnt0", bus.gnt0, 0);
        checkOutput("midreset_sd_lba", bus.sd_lba, 0);
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 8'h00);
        applyStimulus(1, 1'b1, 1'b0, 32'h1111, 8'h00);
        @(posedge clk_ram); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk_ram); #1;
        checkOutput("stale_ack_no_gnt", bus.gnt1, 0);
        c = cyc;
        bus.sd_ack = 1'b0;
        gnt_q.push_back(mkExp(1, 32'h1111, 1'b1, 1'b0, 8'h00, 0, 0, c + 3));
        fork
            clientTxn(1, 1'b1, 1'b0, 32'h1111, 8'h00);
            serveTransfer(1, 1'b0, 2, 2);
        join

        repeat (4) @(posedge clk_ram); #1;
        checkOutput("leftover_gnt", gnt_q.size(), 0);
        checkOutput("leftover_drop", drop_q.size(), 0);
        checkOutput("leftover_done", done_q.size(), 0);
        checkOutput("leftover_err", err_q.size(), 0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
